intt_addrgen: RTL and testbench
===============================

Name: intt_addrgen

Overview:
Address and control sequencer for the inverse NTT (Gentleman-Sande) datapath. It is the counterpart of the NTT address generator. Reads are scattered butterfly pairs, processed with the stage distance growing from 1 to N/2. Write addresses are the read pair delayed by the BFU pipeline. Coefficient storage ping-pongs between two banks each stage. The block drives the shared dual-port coefficient RAMs, the twiddle ROM address, and the BFU enable.

Parameters:
RINGSIZE, 256, polynomial length N (power of two, 8..1024)
LOGN, 8, log2(RINGSIZE) = number of stages
ADDRW, 8, coefficient address width = LOGN
BFU_LAT, 4, cycles from read-address issue to write-address issue (RAM read latency + BFU depth), >=1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to run a full INTT; ignored while busy
valid  in  1  global advance; when 0 every register in the block holds (BFU uses the same qualifier)
busy  out  1  transform in progress
done  out  1  one-cycle pulse after the final write
stage  out  5  current stage s, 0..LOGN-1
rd_en  out  1  read enable, both RAM ports of rd_bank
r_addr_0  out  ADDRW  butterfly upper-input index p0
r_addr_1  out  ADDRW  butterfly lower-input index p1
tw_addr  out  ADDRW-1  twiddle ROM index
rd_bank  out  1  bank being read
bfu_en  out  1  BFU enable = rd_en delayed 1 cycle
wr_en  out  1  write enable, both RAM ports of wr_bank
w_addr_0  out  ADDRW  write index for BFU output 0
w_addr_1  out  ADDRW  write index for BFU output 1
wr_bank  out  1  bank being written

Behaviour:
- Reset: state IDLE; all outputs 0; counters and delay line cleared. Reset mid-transform aborts immediately, with no done pulse.
- FSM: IDLE -> RUN on start. RUN -> DRAIN after butterfly b = N/2-1 is issued. DRAIN -> RUN (s+1, b=0) after BFU_LAT valid cycles if s < LOGN-1. DRAIN -> DONE if s = LOGN-1. DONE -> IDLE after 1 cycle.
- All transitions and counter updates occur only on edges where valid=1. The exception is the IDLE start sample, which also requires valid=1.
- Address math in stage s, butterfly b (0..N/2-1):
  - h = 1<<s; g = b>>s; o = b & (h-1)
  - p0 = g*2h + o; p1 = p0 + h; tw_addr = o << (LOGN-1-s)
  - All values are unsigned and fit in ADDRW bits without wrap.
- Timing: with start sampled at edge E0, cycle 1 has rd_en=1 and r_addr = (0,1). b increments once per valid cycle in RUN.
- rd_en is 1 in RUN only; bfu_en = rd_en delayed 1 cycle.
- wr_en and w_addr_0/1 equal rd_en and r_addr_0/1 delayed exactly BFU_LAT valid cycles, through an enabled shift register.
- The DRAIN length BFU_LAT guarantees that the last write of stage s lands before the first read of stage s+1. Stage period = N/2 + BFU_LAT cycles.
- Banks: rd_bank = s[0]; wr_bank = ~s[0]. Input is read from bank 0. The final result (LOGN even) is written to bank 0.
- busy is 1 from cycle 1 through the cycle of the final wr_en. done pulses in the next cycle, with busy=0 in that cycle.
- rd_en, wr_en and bfu_en are combinationally ANDed with valid. No RAM access occurs on a stalled cycle; addresses hold.
- If start and valid=0 coincide in IDLE, the start is lost; the requester holds start until busy rises.

Decomposition:
- Shared define.v holds Ringsize, Stage, Addrwidth and a new Bfulat constant. The block's parameters default from these.
- One sub-module is natural: addr_delay_line, a BFU_LAT-deep, (2*ADDRW+1)-bit enabled shift register carrying {rd_en, r_addr_0, r_addr_1}. It is reset to 0.

Test Plan:
1. Reset, then a start pulse with valid=1 throughout: rd_en is seen first at cycle 1 with r_addr=(0,1). At b=1 the pair is (2,3) and tw_addr=0. done pulses at cycle 1057 (8*132+1). There are exactly 1024 wr_en cycles.
2. Address spot checks: s=2, b=9 -> (17,21), tw=32. s=7, b=5 -> (5,133), tw=5. Each w_addr equals its r_addr seen 4 valid cycles earlier.
3. Stage boundary: after the read at b=127 of s=0, rd_en=0 for 4 cycles while the last 4 writes occur. The next read is (0,2) at s=1. rd_bank flips 0->1 and wr_bank flips 1->0.
4. Stall: valid held 0 for 10 cycles mid-stage 3. All outputs hold, and rd_en, wr_en and bfu_en are 0. On resume the sequence continues with no skipped or duplicated index, and done arrives 10 cycles late.
5. start pulsed while busy has no effect. Reset asserted mid-stage 5 gives all outputs 0 and no done; a new start then restarts from s=0, b=0.
6. Scoreboard: across a full run, each address 0..255 is written exactly once per stage, per-stage read pairs are disjoint, and wr_bank is 0 in the final stage.

Source files
------------

// File: rtl/intt_addrgen_pkg.sv
// ============================================================================
// Module      : intt_addrgen_pkg
// Description : Shared constants and FSM encoding for the inverse-NTT address
//               sequencer. The *_DEF constants are the project-wide defaults
//               that the sequencer parameters fall back to.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package intt_addrgen_pkg;

    // Project-wide transform geometry (polynomial length, stage count,
    // coefficient address width, read-to-write pipeline depth).
    localparam int RINGSIZE_DEF = 256;
    localparam int STAGE_DEF    = 8;
    localparam int ADDRW_DEF    = 8;
    localparam int BFULAT_DEF   = 4;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage : intt_addrgen_pkg

`default_nettype wire

// File: rtl/intt_addrgen_addr_delay_line.sv
// ============================================================================
// Module      : intt_addrgen_addr_delay_line
// Description : DEPTH-deep enabled shift register that carries the read
//               strobe and read-address pair forward so they reappear as the
//               write strobe and write-address pair once the BFU result is
//               ready. Every tap holds when en_i is low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intt_addrgen_addr_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_tap
        logic [WIDTH-1:0] tap_d;
        logic [WIDTH-1:0] tap_q;

        // Tap 0 takes the fresh read word, later taps take their predecessor.
        if (i == 0) begin : g_head
            assign tap_d = d_i;
        end else begin : g_body
            assign tap_d = g_tap[i-1].tap_q;
        end

        // One pipeline tap, advanced only on qualified cycles.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                tap_q <= '0;
            end else if (en_i) begin
                tap_q <= tap_d;
            end
        end
    end

    assign q_o = g_tap[DEPTH-1].tap_q;

endmodule : intt_addrgen_addr_delay_line

`default_nettype wire

// File: rtl/intt_addrgen.sv
// ============================================================================
// Module      : intt_addrgen
// Description : Address and control sequencer for the Gentleman-Sande inverse
//               NTT. Walks LOGN stages with butterfly distance 1..N/2, issues
//               scattered read pairs plus twiddle index, replays the pairs as
//               write addresses BFU_LAT qualified cycles later, drains the BFU
//               between stages and ping-pongs the coefficient banks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intt_addrgen
    import intt_addrgen_pkg::*;
#(
    parameter int RINGSIZE = RINGSIZE_DEF,
    parameter int LOGN     = STAGE_DEF,
    parameter int ADDRW    = ADDRW_DEF,
    parameter int BFU_LAT  = BFULAT_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             valid_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [4:0]       stage_o,
    output logic             rd_en_o,
    output logic [ADDRW-1:0] r_addr_0_o,
    output logic [ADDRW-1:0] r_addr_1_o,
    output logic [ADDRW-2:0] tw_addr_o,
    output logic             rd_bank_o,
    output logic             bfu_en_o,
    output logic             wr_en_o,
    output logic [ADDRW-1:0] w_addr_0_o,
    output logic [ADDRW-1:0] w_addr_1_o,
    output logic             wr_bank_o
);

    // Butterfly index is 0..N/2-1, so it needs one bit less than an address.
    localparam int BW   = ADDRW - 1;
    localparam int CNTW = (BFU_LAT > 1) ? $clog2(BFU_LAT) : 1;
    localparam int DLW  = 2 * ADDRW + 1;

    localparam logic [BW-1:0]   B_LAST = BW'(RINGSIZE / 2 - 1);
    localparam logic [4:0]      S_LAST = 5'(LOGN - 1);
    localparam logic [CNTW-1:0] C_LAST = CNTW'(BFU_LAT - 1);

    state_e          state_q, state_d;
    logic [4:0]      stage_q, stage_d;
    logic [BW-1:0]   b_q,     b_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic            bfu_q;

    logic            run;
    logic            drain;
    logic [ADDRW-1:0] b_ext;
    logic [ADDRW-1:0] half;
    logic [ADDRW-1:0] mask;
    logic [ADDRW-1:0] grp;
    logic [ADDRW-1:0] off;
    logic [ADDRW-1:0] p0;
    logic [ADDRW-1:0] p1;
    logic [4:0]       tw_shift;
    logic [BW-1:0]    tw;
    logic [DLW-1:0]   dl_d;
    logic [DLW-1:0]   dl_q;

    // Control state, stage, butterfly and drain counters; all hold on stalls.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: nothing moves unless the cycle is qualified by valid.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        if (valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_RUN;
                        stage_d = '0;
                        b_d     = '0;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (b_q == B_LAST) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Wait until the last write of this stage has been issued.
                    if (cnt_q == C_LAST) begin
                        cnt_d = '0;
                        if (stage_q == S_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                            stage_d = stage_q + 1'b1;
                            b_d     = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    stage_d = '0;
                    b_d     = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // BFU enable follows the read strobe by one qualified cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bfu_q <= 1'b0;
        end else if (valid_i) begin
            bfu_q <= run;
        end
    end

    // Butterfly address math: h = 2^s, group g = b >> s, offset o = b mod h.
    // p0 = g*2h + o has bit s clear, so p1 = p0 + h is just that bit set.
    always_comb begin
        b_ext    = {1'b0, b_q};
        half     = ADDRW'(1) << stage_q;
        mask     = half - ADDRW'(1);
        off      = b_ext & mask;
        grp      = b_ext >> stage_q;
        p0       = (grp << (stage_q + 5'd1)) | off;
        p1       = p0 | half;
        tw_shift = S_LAST - stage_q;
        // o < 2^s, so o << (LOGN-1-s) always fits the twiddle index width.
        tw       = off[BW-1:0] << tw_shift;
    end

    assign run   = (state_q == ST_RUN);
    assign drain = (state_q == ST_DRAIN);

    assign busy_o     = run | drain;
    assign done_o     = (state_q == ST_DONE);
    assign stage_o    = stage_q;
    assign rd_en_o    = run & valid_i;
    assign r_addr_0_o = run ? p0 : '0;
    assign r_addr_1_o = run ? p1 : '0;
    assign tw_addr_o  = run ? tw : '0;
    // Stage s reads bank s[0] and writes the other bank; idle shows bank 0.
    assign rd_bank_o  = stage_q[0];
    assign wr_bank_o  = busy_o & ~stage_q[0];
    assign bfu_en_o   = bfu_q & valid_i;

    assign dl_d = {run, r_addr_0_o, r_addr_1_o};

    intt_addrgen_addr_delay_line #(
        .DEPTH (BFU_LAT),
        .WIDTH (DLW)
    ) u_addr_delay_line (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (valid_i),
        .d_i     (dl_d),
        .q_o     (dl_q)
    );

    assign wr_en_o    = dl_q[DLW-1] & valid_i;
    assign w_addr_0_o = dl_q[2*ADDRW-1:ADDRW];
    assign w_addr_1_o = dl_q[ADDRW-1:0];

endmodule : intt_addrgen

`default_nettype wire

// File: tb/tb_intt_addrgen.sv
// ============================================================================
// Module      : tb_intt_addrgen
// Description : Scoreboard bench for the inverse-NTT address sequencer. A
//               reference model fills read/write expectation queues from the
//               stage/butterfly arithmetic; a monitor pops them whenever the
//               DUT strobes rd_en / wr_en and checks timing in valid cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intt_addrgen;

    localparam int N       = 256;
    localparam int LOGN    = 8;
    localparam int AW      = 8;
    localparam int LAT     = 4;
    localparam int PERIOD  = N / 2 + LAT;
    localparam int DONE_AT = LOGN * PERIOD + 1;

    logic          clk = 1'b0;
    logic          reset_i, start_i, valid_i;
    logic          busy_o, done_o, rd_en_o, rd_bank_o, bfu_en_o, wr_en_o, wr_bank_o;
    logic [4:0]    stage_o;
    logic [AW-1:0] r_addr_0_o, r_addr_1_o, w_addr_0_o, w_addr_1_o;
    logic [AW-2:0] tw_addr_o;

    always #5 clk = ~clk;

    intt_addrgen #(
        .RINGSIZE (N),
        .LOGN     (LOGN),
        .ADDRW    (AW),
        .BFU_LAT  (LAT)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .valid_i    (valid_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .stage_o    (stage_o),
        .rd_en_o    (rd_en_o),
        .r_addr_0_o (r_addr_0_o),
        .r_addr_1_o (r_addr_1_o),
        .tw_addr_o  (tw_addr_o),
        .rd_bank_o  (rd_bank_o),
        .bfu_en_o   (bfu_en_o),
        .wr_en_o    (wr_en_o),
        .w_addr_0_o (w_addr_0_o),
        .w_addr_1_o (w_addr_1_o),
        .wr_bank_o  (wr_bank_o)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input bit ok, input string name, input string detail);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    typedef struct {
        int cyc;
        int s;
        int p0;
        int p1;
        int tw;
    } op_t;

    op_t rd_q[$];
    op_t wr_q[$];
    int  vcount = 0;
    int  wr_total = 0;
    int  wr_seen[LOGN][N];
    int  rd_seen[LOGN][N];

    // Reference model: list every butterfly of a full transform in order.
    task automatic push_run();
        op_t e;
        rd_q.delete();
        wr_q.delete();
        for (int s = 0; s < LOGN; s++) begin
            for (int b = 0; b < N / 2; b++) begin
                int h = 2 ** s;
                int g = b / h;
                int o = b % h;
                e.s   = s;
                e.p0  = g * 2 * h + o;
                e.p1  = e.p0 + h;
                e.tw  = o * (2 ** (LOGN - 1 - s));
                e.cyc = 1 + s * PERIOD + b;
                rd_q.push_back(e);
                e.cyc = e.cyc + LAT;
                wr_q.push_back(e);
            end
        end
        for (int s = 0; s < LOGN; s++) begin
            for (int a = 0; a < N; a++) begin
                wr_seen[s][a] = 0;
                rd_seen[s][a] = 0;
            end
        end
        wr_total = 0;
    endtask

    function automatic logic [63:0] snap();
        return {busy_o, done_o, stage_o, r_addr_0_o, r_addr_1_o, tw_addr_o,
                rd_bank_o, w_addr_0_o, w_addr_1_o, wr_bank_o};
    endfunction

    function automatic bit all_zero();
        return !(busy_o | done_o | (|stage_o) | rd_en_o | (|r_addr_0_o) | (|r_addr_1_o) |
                 (|tw_addr_o) | rd_bank_o | bfu_en_o | wr_en_o | (|w_addr_0_o) |
                 (|w_addr_1_o) | wr_bank_o);
    endfunction

    // Qualified-cycle counter: cycle 1 is the cycle after the start edge.
    always @(posedge clk) begin
        if (!reset_i && valid_i) begin
            if (start_i && !busy_o && !done_o) vcount = 1;
            else                               vcount = vcount + 1;
        end
    end

    logic        last_rd    = 1'b0;
    logic        prev_valid = 1'b1;
    logic        prev_done  = 1'b0;
    logic [63:0] prev_snap  = '0;

    // Monitor: pops and compares on every strobe, checks stall behaviour.
    always @(negedge clk) begin
        op_t e;
        if (reset_i) begin
            last_rd    = 1'b0;
            prev_valid = 1'b1;
        end else begin
            if (rd_en_o) begin
                if (rd_q.size() == 0) begin
                    chk(1'b0, "rd_unexpected", $sformatf("read (%0d,%0d) at cycle %0d, none expected",
                        r_addr_0_o, r_addr_1_o, vcount));
                end else begin
                    e = rd_q.pop_front();
                    chk(vcount == e.cyc && int'(stage_o) == e.s && int'(r_addr_0_o) == e.p0 &&
                        int'(r_addr_1_o) == e.p1 && int'(tw_addr_o) == e.tw &&
                        rd_bank_o == e.s[0],
                        "rd_seq", $sformatf("got cyc=%0d s=%0d p=(%0d,%0d) tw=%0d bank=%0d; want cyc=%0d s=%0d p=(%0d,%0d) tw=%0d bank=%0d",
                        vcount, stage_o, r_addr_0_o, r_addr_1_o, tw_addr_o, rd_bank_o,
                        e.cyc, e.s, e.p0, e.p1, e.tw, e.s[0]));
                    rd_seen[e.s][r_addr_0_o]++;
                    rd_seen[e.s][r_addr_1_o]++;
                end
            end
            if (wr_en_o) begin
                if (wr_q.size() == 0) begin
                    chk(1'b0, "wr_unexpected", $sformatf("write (%0d,%0d) at cycle %0d, none expected",
                        w_addr_0_o, w_addr_1_o, vcount));
                end else begin
                    e = wr_q.pop_front();
                    chk(vcount == e.cyc && int'(w_addr_0_o) == e.p0 && int'(w_addr_1_o) == e.p1 &&
                        wr_bank_o == !e.s[0],
                        "wr_seq", $sformatf("got cyc=%0d p=(%0d,%0d) bank=%0d; want cyc=%0d p=(%0d,%0d) bank=%0d",
                        vcount, w_addr_0_o, w_addr_1_o, wr_bank_o, e.cyc, e.p0, e.p1, !e.s[0]));
                    wr_seen[e.s][w_addr_0_o]++;
                    wr_seen[e.s][w_addr_1_o]++;
                    wr_total++;
                end
            end
            if (done_o && !prev_done) begin
                chk(vcount == DONE_AT && !busy_o && rd_q.size() == 0 && wr_q.size() == 0,
                    "done", $sformatf("got cyc=%0d busy=%0d pending rd=%0d wr=%0d; want cyc=%0d busy=0 pending 0/0",
                    vcount, busy_o, rd_q.size(), wr_q.size(), DONE_AT));
            end
            if (valid_i) begin
                chk(bfu_en_o == last_rd, "bfu_en",
                    $sformatf("got %0d want %0d at cycle %0d", bfu_en_o, last_rd, vcount));
                last_rd = rd_en_o;
            end else begin
                chk(!rd_en_o && !wr_en_o && !bfu_en_o, "stall_gate",
                    $sformatf("got rd=%0d wr=%0d bfu=%0d want 0/0/0", rd_en_o, wr_en_o, bfu_en_o));
            end
            if (!prev_valid) begin
                chk(snap() == prev_snap, "stall_hold",
                    $sformatf("got %h want %h", snap(), prev_snap));
            end
            prev_valid = valid_i;
        end
        prev_snap = snap();
        prev_done = done_o;
    end

    // Full transform; mode 1 randomizes valid and inserts a 10-cycle stall in stage 3.
    task automatic run_full(input int mode);
        int guard = 0;
        int burst = 0;
        bit burst_done = 1'b0;
        int bad;
        push_run();
        @(posedge clk); #1;
        start_i = 1'b1;
        valid_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (!done_o && guard < 6000) begin
            if (mode == 1) begin
                if (!burst_done && stage_o == 5'd3 && rd_en_o == 1'b0 && busy_o && guard > 420) begin
                    burst      = 10;
                    burst_done = 1'b1;
                end
                if (!burst_done && stage_o == 5'd3 && busy_o && $urandom_range(0, 15) == 0) begin
                    burst      = 10;
                    burst_done = 1'b1;
                end
                if (burst > 0) begin
                    valid_i = 1'b0;
                    burst--;
                end else begin
                    valid_i = ($urandom_range(0, 9) != 0);
                end
            end else begin
                valid_i = 1'b1;
            end
            // Stray start requests while busy must be ignored.
            start_i = (busy_o && $urandom_range(0, 49) == 0);
            @(posedge clk); #1;
            guard++;
        end
        start_i = 1'b0;
        valid_i = 1'b1;
        chk(done_o == 1'b1, "run_timeout", $sformatf("done=%0d after %0d cycles, want 1", done_o, guard));
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk(wr_total == LOGN * N / 2, "wr_count", $sformatf("got %0d want %0d", wr_total, LOGN * N / 2));
        for (int s = 0; s < LOGN; s++) begin
            bad = 0;
            for (int a = 0; a < N; a++) begin
                if (wr_seen[s][a] != 1) bad++;
                if (rd_seen[s][a] != 1) bad++;
            end
            chk(bad == 0, "stage_coverage", $sformatf("stage %0d: %0d addresses not read/written exactly once, want 0", s, bad));
        end
    endtask

    // Start a run, reset it in stage 5, confirm it goes quiet.
    task automatic run_abort();
        int guard = 0;
        bit seen = 1'b0;
        push_run();
        @(posedge clk); #1;
        start_i = 1'b1;
        valid_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (stage_o != 5'd5 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (37) begin
            @(posedge clk); #1;
        end
        chk(stage_o == 5'd5 && busy_o, "abort_reach", $sformatf("got stage=%0d busy=%0d want 5/1", stage_o, busy_o));
        reset_i = 1'b1;
        rd_q.delete();
        wr_q.delete();
        @(negedge clk);
        chk(all_zero(), "abort_outputs", $sformatf("got %h want all zero", snap()));
        @(posedge clk); #1;
        reset_i = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | done_o | busy_o | rd_en_o | wr_en_o;
        end
        chk(!seen, "abort_quiet", $sformatf("activity=%0d after abort, want 0", seen));
    endtask

    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        valid_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(all_zero(), "reset_outputs", $sformatf("got %h want all zero", snap()));
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk(all_zero(), "idle_outputs", $sformatf("got %h want all zero", snap()));

        run_full(0);
        run_full(1);
        run_abort();
        run_full(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_intt_addrgen

`default_nettype wire
